target_driver: RTL

Fetches stimulus entries from the stimulus FIFO read port, drives the vector onto the selected target design, holds it for the cycle count carried in the entry, and captures the target response. Each response is pushed into the result FIFO write port. Sits in the `fifo_clock` domain opposite `test_controller`: it is the consumer of `sfifo` and the producer of `rfifo`.

---
 rtl/target_driver_pkg.sv | 22 ++
 rtl/target_driver_sync2.sv | 24 ++
 rtl/target_driver.sv | 130 +++++++++++++
 3 files changed

// File: rtl/target_driver_pkg.sv
// Shared types and constants for target_driver: FSM state encodings, stimulus
// entry field offsets and the minimum hold count.
package target_driver_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_FETCH   = 3'd1;
  localparam state_t ST_LOAD    = 3'd2;
  localparam state_t ST_HOLD    = 3'd3;
  localparam state_t ST_CAPTURE = 3'd4;
  localparam state_t ST_PUSH    = 3'd5;

  localparam int VEC_LSB  = 0;
  localparam int HOLD_MIN = 1;

  // The hold-count field sits directly above the vector field.
  function automatic int cnt_lsb(input int stf_width);
    return stf_width;
  endfunction

endpackage

// File: rtl/target_driver_sync2.sv
// Two-flop synchronizer, parameterised width, async active-low reset to 0.
// Used by target_driver only when TARGET_DRIVER_OUT_SYNC_EN is defined.
module sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/target_driver.sv
// Stimulus FIFO consumer / result FIFO producer: fetch entry, drive and hold
// the vector, capture the response, push it. Option: TARGET_DRIVER_OUT_SYNC_EN.
//
// state   | meaning
// IDLE    | waiting for enable and a non-empty stimulus FIFO
// FETCH   | one-cycle stimulus FIFO read request
// LOAD    | entry valid on sfifo_dataq; register vector and hold count
// HOLD    | vector stable on dut_in; count down the hold time
// CAPTURE | register the target response
// PUSH    | write the response once the result FIFO has room
module target_driver
  import target_driver_pkg::*;
#(
  parameter int STF_WIDTH   = 24,
  parameter int RTF_WIDTH   = 24,
  parameter int CYCLE_RANGE = 5,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                             clock,
  input  logic                             reset_n,
  input  logic                             enable,
  output logic                             sfifo_rdreq,
  input  logic                             sfifo_rdempty,
  input  logic [STF_WIDTH+CYCLE_RANGE:0]   sfifo_dataq,
  output logic [RTF_WIDTH-1:0]             rfifo_data,
  output logic                             rfifo_wrreq,
  input  logic                             rfifo_wrfull,
  output logic [STF_WIDTH-1:0]             dut_in,
  input  logic [RTF_WIDTH-1:0]             dut_out,
  output logic                             busy,
  output logic [CNT_WIDTH-1:0]             vec_count
);

  localparam int CW      = CYCLE_RANGE + 1;
  localparam int HW      = CYCLE_RANGE + 2;
  localparam int CNT_LSB = cnt_lsb(STF_WIDTH);

  state_t           state;
  state_t           state_nxt;
  logic [HW-1:0]    hold_cnt;
  logic [STF_WIDTH-1:0] vec_in;
  logic [CW-1:0]    c_in;
  logic [CW-1:0]    c_eff;
  logic [HW-1:0]    hold_load;
  logic [RTF_WIDTH-1:0] resp;
  logic             fetch_ok;
  logic             wr_go;

`ifdef TARGET_DRIVER_OUT_SYNC_EN
  // Synchronizer adds two cycles of pipeline, so HOLD is stretched to match.
  localparam int SYNC_EXTRA = 2;

  sync2 #(
    .WIDTH (RTF_WIDTH)
  ) u_sync2 (
    .clock   (clock),
    .reset_n (reset_n),
    .d       (dut_out),
    .q       (resp)
  );
`else
  localparam int SYNC_EXTRA = 0;

  assign resp = dut_out;
`endif

  assign vec_in    = sfifo_dataq[VEC_LSB +: STF_WIDTH];
  assign c_in      = sfifo_dataq[CNT_LSB +: CW];
  assign c_eff     = (c_in < CW'(HOLD_MIN)) ? CW'(HOLD_MIN) : c_in;
  assign hold_load = {1'b0, c_eff} + HW'(SYNC_EXTRA);

  assign fetch_ok    = enable && !sfifo_rdempty;
  assign wr_go       = (state == ST_PUSH) && !rfifo_wrfull;
  assign sfifo_rdreq = (state == ST_FETCH);
  assign rfifo_wrreq = wr_go;
  assign busy        = (state != ST_IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (fetch_ok) state_nxt = ST_FETCH;
      ST_FETCH:   state_nxt = ST_LOAD;
      ST_LOAD:    state_nxt = ST_HOLD;
      ST_HOLD:    if (hold_cnt == HW'(1)) state_nxt = ST_CAPTURE;
      ST_CAPTURE: state_nxt = ST_PUSH;
      ST_PUSH: begin
        if (!rfifo_wrfull) state_nxt = fetch_ok ? ST_FETCH : ST_IDLE;
      end
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hold_cnt <= '0;
      dut_in   <= '0;
    end else if (state == ST_LOAD) begin
      hold_cnt <= hold_load;
      dut_in   <= vec_in;
    end else if (state == ST_HOLD) begin
      hold_cnt <= hold_cnt - HW'(1);
    end
  end

  // rfifo_data only changes in CAPTURE, so it stays put while PUSH stalls.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rfifo_data <= '0;
    end else if (state == ST_CAPTURE) begin
      rfifo_data <= resp;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vec_count <= '0;
    end else if (wr_go) begin
      vec_count <= vec_count + CNT_WIDTH'(1);
    end
  end

endmodule
